// File: rtl/adder_pkg.sv
// adder_pkg: shared width default and extended-result type for the adder datapath
package adder_pkg;
    localparam int ADDER_WIDTH_DEFAULT = 4;
    typedef logic [ADDER_WIDTH_DEFAULT:0] adder_ext_t;
endpackage

// File: rtl/adder_4bit_reg_full_adder.sv
// full_adder: single combinational full-adder cell of the ripple chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/adder_4bit_reg.sv
// adder_4bit_reg: registered ripple-carry adder {Cout,S} = A + B + Cin; ADDER_OVERFLOW_FLAG_EN adds Ovf
module adder_4bit_reg
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
`ifdef ADDER_OVERFLOW_FLAG_EN
    output logic             Ovf,
`endif
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    assign c[0] = Cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (.a(A[i]), .b(B[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
    // S/Cout only load on valid, so undefined idle operands never reach the registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S         <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= s;
                Cout <= c[WIDTH];
            end
        end
    end
`ifdef ADDER_OVERFLOW_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) Ovf <= 1'b0;
        else if (in_valid) Ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
`endif
endmodule

// File: tb/tb_adder_4bit_reg.sv
// tb_adder_4bit_reg: scoreboard bench with directed vectors and hand-computed results
module tb_adder_4bit_reg;
    import adder_pkg::*;
    typedef struct packed {
        adder_ext_t sum;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A, B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       out_valid;
`ifdef ADDER_OVERFLOW_FLAG_EN
    logic       Ovf;
`endif

    int   checks = 0;
    int   fails  = 0;
    exp_t q[$];

    adder_4bit_reg #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .Cin(Cin),
        .S(S), .Cout(Cout),
`ifdef ADDER_OVERFLOW_FLAG_EN
        .Ovf(Ovf),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic [3:0] es, input logic ec, input logic eo);
        A = a; B = b; Cin = ci; in_valid = 1'b1;
        q.push_back('{sum: {ec, es}, ovf: eo});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("sum", int'(S), int'(e.sum[3:0]));
                    chk("cout", int'(Cout), int'(e.sum[4]));
`ifdef ADDER_OVERFLOW_FLAG_EN
                    chk("ovf", int'(Ovf), int'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #1;
        chk("rst_s", int'(S), 0);
        chk("rst_cout", int'(Cout), 0);
        chk("rst_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1);
        idle();
        send(4'd7, 4'd3, 1'b1, 4'd11, 1'b0, 1'b1);
        idle();
        send(4'd9, 4'd4, 1'b0, 4'd13, 1'b0, 1'b0);
        send(4'd14, 4'd1, 1'b0, 4'd15, 1'b0, 1'b0);
        send(4'd14, 4'd1, 1'b1, 4'd0, 1'b1, 1'b0);
        send(4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
        send(4'd8, 4'd8, 1'b0, 4'd0, 1'b1, 1'b1);
        send(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
        A = '0; B = '0; Cin = 1'b0;
        idle();
        chk("hold_s", int'(S), 15);
        chk("hold_cout", int'(Cout), 1);
        chk("hold_valid", int'(out_valid), 0);
`ifdef ADDER_OVERFLOW_FLAG_EN
        chk("hold_ovf", int'(Ovf), 0);
`endif
        // async reset mid-cycle while a valid input is pending: result must be dropped
        #1;
        A = 4'd1; B = 4'd1; in_valid = 1'b1; rst = 1'b1;
        #1;
        chk("arst_s", int'(S), 0);
        chk("arst_cout", int'(Cout), 0);
        chk("arst_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("arst_hold_s", int'(S), 0);
        chk("arst_hold_valid", int'(out_valid), 0);
        rst = 1'b0; in_valid = 1'b0;
        idle();
        send(4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1);
        repeat (3) idle();
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
